// File: rtl/instr_encode_loader.sv
// Packs MIPS instruction descriptions into 32-bit words and writes them to instruction memory.
// Latency: a description accepted in cycle N is written (mem_we) in cycle N+1.
// Backpressure: in_ready only in ACCEPT, so at most one word per two cycles.
module instr_encode_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_ACCEPT, S_WRITE, S_DONE, S_ERROR} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_last;
    logic [31:0]       w_enc;
    logic              w_legal;
    logic [ADDR_W:0]   w_count_inc;

    assign w_count_inc = r_count + 1'b1;

    always_comb begin
        w_enc   = '0;
        w_legal = 1'b1;
        case (in_class)
            3'd0:    w_enc = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            3'd1:    w_enc = {6'b100011, in_rs, in_rt, in_imm};
            3'd2:    w_enc = {6'b101011, in_rs, in_rt, in_imm};
            3'd3:    w_enc = {6'b000100, in_rs, in_rt, in_imm};
            3'd4:    w_enc = {6'b001000, in_rs, in_rt, in_imm};
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACCEPT: if (in_valid) w_state_nxt = w_legal ? S_WRITE : S_ERROR;
            // A final word that exactly fills memory is a complete program, not an overflow.
            S_WRITE: begin
                if (r_last)                    w_state_nxt = S_DONE;
                else if (w_count_inc == DEPTH) w_state_nxt = S_ERROR;
                else                           w_state_nxt = S_ACCEPT;
            end
            S_DONE:   if (start) w_state_nxt = S_ACCEPT;
            S_ERROR:  w_state_nxt = S_ERROR;
            default:  w_state_nxt = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ACCEPT;
            r_wdata <= '0;
            r_addr  <= BASE;
            r_count <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_ACCEPT && in_valid && w_legal) begin
                r_wdata <= w_enc;
                r_last  <= in_last;
            end
            if (r_state == S_WRITE) begin
                r_count <= w_count_inc;
                r_addr  <= r_addr + 1'b1;
            end
            if (r_state == S_DONE && start) begin
                r_count <= '0;
                r_addr  <= BASE;
            end
        end
    end

    // Decoded from the state register so reset drops mem_we without waiting for a clock.
    assign in_ready  = (r_state == S_ACCEPT);
    assign mem_we    = (r_state == S_WRITE);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERROR);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: full-size instance plus a 4-word instance on shared stimulus.
// Latency: checks the write one cycle after each accept.
// Backpressure: exercised with randomly toggled in_valid.
module tb_instr_encode_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_class = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]  in_funct = '0;
    logic [15:0] in_imm = '0;
    logic        in_last = 1'b0;

    logic        in_ready, mem_we, done, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;

    logic        s_in_ready, s_mem_we, s_done, s_err;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_count;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_we = 0;
    int          we_base;
    logic        prev_we = 1'b0;
    logic [7:0]  exp_addr = '0;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .err(err)
    );

    instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .count(s_count), .done(s_done), .err(s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write strobe must never be high on two consecutive cycles.
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                n_we++;
                chk("we_back_to_back", {31'b0, prev_we}, 32'd0);
            end
            prev_we = mem_we;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_addr = '0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Offer one description, wait for acceptance, then check the write the next cycle.
    task automatic send(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic last, input logic rnd,
                        input logic [31:0] exp_w);
        logic ok;
        in_class = c; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_last = last;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", {31'b0, ok}, 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("write_we", {31'b0, mem_we}, 32'd1);
        chk("write_ready", {31'b0, in_ready}, 32'd0);
        chk("write_addr", {24'b0, mem_addr}, {24'b0, exp_addr});
        chk("write_data", mem_wdata, exp_w);
        exp_addr = exp_addr + 8'd1;
    endtask

    initial begin
        start = 1'b1;  // start coincident with reset must be ignored
        @(negedge clk);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", {24'b0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_count", {23'b0, count}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, in_ready}, 32'd1);

        // Five-instruction program
        we_base = n_we;
        send(3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0000, 1'b0, 1'b0, 32'h01095020);
        send(3'd1, 5'd16, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004, 1'b0, 1'b0, 32'h8E080004);
        send(3'd2, 5'd16, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 1'b0, 1'b0, 32'hAE080004);
        send(3'd3, 5'd8, 5'd9, 5'd0, 5'd0, 6'h00, 16'hFFFF, 1'b0, 1'b0, 32'h1109FFFF);
        send(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 1'b1, 1'b0, 32'h20080005);
        @(negedge clk);
        chk("prog_count", {23'b0, count}, 32'd5);
        chk("prog_done", {31'b0, done}, 32'd1);
        chk("prog_ready", {31'b0, in_ready}, 32'd0);
        chk("prog_wdata_hold", mem_wdata, 32'h20080005);
        chk("prog_we_pulses", n_we - we_base, 32'd5);

        // Rerun from DONE
        pulse_start();
        @(negedge clk);
        chk("rerun_done", {31'b0, done}, 32'd0);
        chk("rerun_count0", {23'b0, count}, 32'd0);
        chk("rerun_addr0", {24'b0, mem_addr}, 32'd0);
        exp_addr = '0;
        send(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0007, 1'b0, 1'b0, 32'h20010007);
        @(negedge clk);
        chk("rerun_count1", {23'b0, count}, 32'd1);
        pulse_start();  // outside DONE: no effect
        @(negedge clk);
        chk("start_ignored_count", {23'b0, count}, 32'd1);
        chk("start_ignored_addr", {24'b0, mem_addr}, 32'd1);

        // Illegal class after one good word
        do_reset();
        send(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0001, 1'b0, 1'b0, 32'h20010001);
        in_class = 3'd6; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("illegal_err", {31'b0, err}, 32'd1);
        chk("illegal_we", {31'b0, mem_we}, 32'd0);
        chk("illegal_count", {23'b0, count}, 32'd1);
        chk("illegal_ready", {31'b0, in_ready}, 32'd0);
        pulse_start();
        @(negedge clk);
        chk("err_sticky", {31'b0, err}, 32'd1);
        chk("err_not_done", {31'b0, done}, 32'd0);
        do_reset();
        @(negedge clk);
        chk("err_cleared", {31'b0, err}, 32'd0);
        chk("err_cleared_ready", {31'b0, in_ready}, 32'd1);

        // Four-word memory: overflow, then exact fill with in_last
        for (int k = 0; k < 4; k++)
            send(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'(k + 2), 1'b0, 1'b0, 32'h20010002 + k);
        @(negedge clk);
        chk("full_err", {31'b0, s_err}, 32'd1);
        chk("full_count", {29'b0, s_count}, 32'd4);
        chk("full_ready", {31'b0, s_in_ready}, 32'd0);
        chk("full_we", {31'b0, s_mem_we}, 32'd0);
        chk("full_addr_wrap", {30'b0, s_mem_addr}, 32'd0);
        chk("full_wdata", s_mem_wdata, 32'h20010005);
        chk("big_not_full", {31'b0, in_ready}, 32'd1);
        do_reset();
        for (int k = 0; k < 4; k++)
            send(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'(k + 8), k == 3, 1'b0, 32'h20010008 + k);
        @(negedge clk);
        chk("exact_done", {31'b0, s_done}, 32'd1);
        chk("exact_err", {31'b0, s_err}, 32'd0);
        chk("exact_count", {29'b0, s_count}, 32'd4);

        // Reset during a WRITE cycle
        do_reset();
        send(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0001, 1'b0, 1'b0, 32'h20010001);
        send(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0002, 1'b0, 1'b0, 32'h20010002);
        in_class = 3'd4; in_imm = 16'h0003; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        chk("midrst_we_before", {31'b0, mem_we}, 32'd1);
        chk("midrst_addr_before", {24'b0, mem_addr}, 32'd2);
        rst = 1'b1;
        #1;
        chk("midrst_we", {31'b0, mem_we}, 32'd0);
        chk("midrst_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_addr", {24'b0, mem_addr}, 32'd0);
        chk("midrst_count", {23'b0, count}, 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        chk("midrst_flags", {30'b0, done, err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_addr = '0;
        send(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0009, 1'b0, 1'b0, 32'h20010009);
        @(negedge clk);
        chk("midrst_count_after", {23'b0, count}, 32'd1);

        // Random in_valid backpressure
        do_reset();
        we_base = n_we;
        for (int k = 0; k < 6; k++)
            send(3'd3, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'(k * 16'h11), k == 5, 1'b1,
                 32'h10430000 + k * 32'h11);
        repeat (4) @(negedge clk);
        chk("bp_we_pulses", n_we - we_base, 32'd6);
        chk("bp_count", {23'b0, count}, 32'd6);
        chk("bp_done", {31'b0, done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
